// File: rtl/hyperbus_burst_splitter_pkg.sv
// ============================================================================
// Module   : hyperbus_pkg
// Purpose  : Shared transaction type and field encodings for the burst splitter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hyperbus_pkg;

  localparam int unsigned C_BURST_WIDTH = 12;
  localparam int unsigned C_NR_CS       = 2;
  localparam int unsigned C_ADDR_WIDTH  = 32;

  localparam logic C_BURST_TYPE_WRAPPED = 1'b0;
  localparam logic C_BURST_TYPE_LINEAR  = 1'b1;
  localparam logic C_ADDR_SPACE_MEMORY   = 1'b0;
  localparam logic C_ADDR_SPACE_REGISTER = 1'b1;

  typedef struct packed {
    logic [C_NR_CS-1:0]       cs;
    logic                     write;
    logic [C_BURST_WIDTH-1:0] burst;
    logic                     burst_type;
    logic                     address_space;
    logic [C_ADDR_WIDTH-1:0]  address;
  } trans_struct;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } splitter_state_e;

endpackage

`default_nettype wire

// File: rtl/hyperbus_burst_splitter_if.sv
// ============================================================================
// Module   : hyperbus_burst_splitter_if
// Purpose  : Transaction, response and read-data bundle around the splitter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hyperbus_burst_splitter_if
  import hyperbus_pkg::*;
#(
  parameter int unsigned BURST_WIDTH = C_BURST_WIDTH,
  parameter int unsigned NR_CS       = C_NR_CS,
  parameter int unsigned ADDR_WIDTH  = C_ADDR_WIDTH
) ();

  logic [BURST_WIDTH-1:0] cfg_max_burst_i;

  logic                   in_trans_valid_i;
  logic                   in_trans_ready_o;
  logic [ADDR_WIDTH-1:0]  in_trans_address_i;
  logic [NR_CS-1:0]       in_trans_cs_i;
  logic                   in_trans_write_i;
  logic                   in_trans_burst_type_i;
  logic                   in_trans_address_space_i;
  logic [BURST_WIDTH-1:0] in_trans_burst_i;

  logic                   out_trans_valid_o;
  logic                   out_trans_ready_i;
  logic [ADDR_WIDTH-1:0]  out_trans_address_o;
  logic [NR_CS-1:0]       out_trans_cs_o;
  logic                   out_trans_write_o;
  logic                   out_trans_burst_type_o;
  logic                   out_trans_address_space_o;
  logic [BURST_WIDTH-1:0] out_trans_burst_o;

  logic                   phy_b_valid_i;
  logic                   phy_b_error_i;
  logic                   b_valid_o;
  logic                   b_ready_i;
  logic                   b_error_o;

  logic                   phy_rx_valid_i;
  logic                   phy_rx_ready_o;
  logic [15:0]            phy_rx_data_i;
  logic                   phy_rx_last_i;
  logic                   phy_rx_error_i;
  logic                   rx_valid_o;
  logic                   rx_ready_i;
  logic [15:0]            rx_data_o;
  logic                   rx_last_o;
  logic                   rx_error_o;

  // slave: the splitter's own view; master: the surrounding AXI side and PHY
  modport slave (
    input  cfg_max_burst_i,
    input  in_trans_valid_i, in_trans_address_i, in_trans_cs_i, in_trans_write_i,
    input  in_trans_burst_type_i, in_trans_address_space_i, in_trans_burst_i,
    output in_trans_ready_o,
    output out_trans_valid_o, out_trans_address_o, out_trans_cs_o, out_trans_write_o,
    output out_trans_burst_type_o, out_trans_address_space_o, out_trans_burst_o,
    input  out_trans_ready_i,
    input  phy_b_valid_i, phy_b_error_i, b_ready_i,
    output b_valid_o, b_error_o,
    input  phy_rx_valid_i, phy_rx_data_i, phy_rx_last_i, phy_rx_error_i, rx_ready_i,
    output phy_rx_ready_o, rx_valid_o, rx_data_o, rx_last_o, rx_error_o
  );

  modport master (
    output cfg_max_burst_i,
    output in_trans_valid_i, in_trans_address_i, in_trans_cs_i, in_trans_write_i,
    output in_trans_burst_type_i, in_trans_address_space_i, in_trans_burst_i,
    input  in_trans_ready_o,
    input  out_trans_valid_o, out_trans_address_o, out_trans_cs_o, out_trans_write_o,
    input  out_trans_burst_type_o, out_trans_address_space_o, out_trans_burst_o,
    output out_trans_ready_i,
    output phy_b_valid_i, phy_b_error_i, b_ready_i,
    input  b_valid_o, b_error_o,
    output phy_rx_valid_i, phy_rx_data_i, phy_rx_last_i, phy_rx_error_i, rx_ready_i,
    input  phy_rx_ready_o, rx_valid_o, rx_data_o, rx_last_o, rx_error_o
  );

endinterface

`default_nettype wire

// File: rtl/hyperbus_burst_splitter_chunk_calc.sv
// ============================================================================
// Module   : hyperbus_chunk_calc
// Purpose  : Next chunk length = min(remaining, max burst, words to page end)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyperbus_chunk_calc
  import hyperbus_pkg::*;
#(
  parameter int unsigned BURST_WIDTH = C_BURST_WIDTH,
  parameter int unsigned PAGE_LOG2   = 9
) (
  input  wire logic [BURST_WIDTH-1:0] i_remaining,
  input  wire logic [BURST_WIDTH-1:0] i_cfg_max_burst,
  input  wire logic [PAGE_LOG2-1:0]   i_page_offset,
  input  wire logic                   i_pass_through,
  output logic      [BURST_WIDTH-1:0] o_chunk
);

  // Wide enough for both the burst fields and a full page (2^PAGE_LOG2)
  localparam int unsigned CALC_W = (BURST_WIDTH > PAGE_LOG2) ? BURST_WIDTH : PAGE_LOG2 + 1;

  logic [CALC_W-1:0] w_room;
  logic [CALC_W-1:0] w_remaining;
  logic [CALC_W-1:0] w_limit;
  logic [CALC_W-1:0] w_min_len;
  logic [CALC_W-1:0] w_min_all;

  always_comb begin
    w_room      = (CALC_W'(1) << PAGE_LOG2) - CALC_W'(i_page_offset);
    w_remaining = CALC_W'(i_remaining);
    w_limit     = (i_cfg_max_burst == '0) ? w_remaining : CALC_W'(i_cfg_max_burst);
    w_min_len   = (w_limit < w_remaining) ? w_limit : w_remaining;
    w_min_all   = (w_room < w_min_len) ? w_room : w_min_len;
    o_chunk     = i_pass_through ? i_remaining : BURST_WIDTH'(w_min_all);
  end

endmodule

`default_nettype wire

// File: rtl/hyperbus_burst_splitter.sv
// ============================================================================
// Module   : hyperbus_burst_splitter
// Purpose  : Splits linear bursts at max-length/page limits, merges responses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyperbus_burst_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned BURST_WIDTH = C_BURST_WIDTH,
  parameter int unsigned NR_CS       = C_NR_CS,
  parameter int unsigned ADDR_WIDTH  = C_ADDR_WIDTH,
  parameter int unsigned PAGE_LOG2   = 9,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input wire logic clk_i,
  input wire logic rst_ni,
  hyperbus_burst_splitter_if.slave bus
);

  splitter_state_e        r_state;
  logic [ADDR_WIDTH-1:0]  r_cur_addr;
  logic [BURST_WIDTH-1:0] r_remaining;
  logic [BURST_WIDTH-1:0] r_burst_hold;
  logic                   r_hold_valid;
  logic [NR_CS-1:0]       r_cs;
  logic                   r_write;
  logic                   r_burst_type;
  logic                   r_address_space;
  logic [CNT_WIDTH-1:0]   r_issued;
  logic [CNT_WIDTH-1:0]   r_done;
  logic                   r_err;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_b_valid;
  logic                   r_b_error;

  logic                   w_pass_through;
  logic [BURST_WIDTH-1:0] w_chunk;
  logic [BURST_WIDTH-1:0] w_out_burst;
  logic [BURST_WIDTH-1:0] w_remaining_next;
  logic                   w_out_fire;
  logic                   w_rx_fire;
  logic                   w_completion;
  logic [CNT_WIDTH-1:0]   w_done_next;
  logic [CNT_WIDTH-1:0]   w_issued_next;
  logic                   w_err_next;

  assign w_pass_through = (r_address_space == C_ADDR_SPACE_REGISTER) ||
                          (r_burst_type == C_BURST_TYPE_WRAPPED);

  hyperbus_chunk_calc #(
    .BURST_WIDTH (BURST_WIDTH),
    .PAGE_LOG2   (PAGE_LOG2)
  ) u_chunk_calc (
    .i_remaining     (r_remaining),
    .i_cfg_max_burst (bus.cfg_max_burst_i),
    .i_page_offset   (r_cur_addr[PAGE_LOG2:1]),
    .i_pass_through  (w_pass_through),
    .o_chunk         (w_chunk)
  );

  // A stalled chunk keeps its length even if the max-burst setting moves
  assign w_out_burst      = r_hold_valid ? r_burst_hold : w_chunk;
  assign w_out_fire       = r_out_valid && bus.out_trans_ready_i;
  assign w_remaining_next = r_remaining - w_out_burst;
  assign w_rx_fire        = bus.phy_rx_valid_i && bus.rx_ready_i;
  assign w_completion     = (r_state != ST_IDLE) &&
                            (r_write ? bus.phy_b_valid_i : (w_rx_fire && bus.phy_rx_last_i));
  assign w_done_next      = r_done + CNT_WIDTH'(w_completion);
  assign w_issued_next    = r_issued + CNT_WIDTH'(w_out_fire);
  assign w_err_next       = r_err || ((r_state != ST_IDLE) && bus.phy_b_valid_i && bus.phy_b_error_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state         <= ST_IDLE;
      r_cur_addr      <= '0;
      r_remaining     <= '0;
      r_burst_hold    <= '0;
      r_hold_valid    <= 1'b0;
      r_cs            <= '0;
      r_write         <= 1'b0;
      r_burst_type    <= 1'b0;
      r_address_space <= 1'b0;
      r_issued        <= '0;
      r_done          <= '0;
      r_err           <= 1'b0;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_b_valid       <= 1'b0;
      r_b_error       <= 1'b0;
    end else begin
      r_done   <= w_done_next;
      r_issued <= w_issued_next;
      r_err    <= w_err_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_trans_valid_i) begin
            r_cur_addr      <= bus.in_trans_address_i;
            r_remaining     <= bus.in_trans_burst_i;
            r_cs            <= bus.in_trans_cs_i;
            r_write         <= bus.in_trans_write_i;
            r_burst_type    <= bus.in_trans_burst_type_i;
            r_address_space <= bus.in_trans_address_space_i;
            r_hold_valid    <= 1'b0;
            r_issued        <= '0;
            r_done          <= '0;
            r_err           <= 1'b0;
            r_in_ready      <= 1'b0;
            r_out_valid     <= 1'b1;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_out_valid && !bus.out_trans_ready_i) begin
            r_hold_valid <= 1'b1;
            r_burst_hold <= w_out_burst;
          end
          if (w_out_fire) begin
            r_hold_valid <= 1'b0;
            r_cur_addr   <= r_cur_addr + ADDR_WIDTH'({w_out_burst, 1'b0});
            r_remaining  <= w_remaining_next;
            if (w_remaining_next == '0) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_done == r_issued) begin
            if (r_write) begin
              r_b_valid <= 1'b1;
              r_b_error <= r_err;
              r_state   <= ST_RESP;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_RESP: begin
          if (bus.b_ready_i) begin
            r_b_valid  <= 1'b0;
            r_b_error  <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_trans_ready_o          = r_in_ready;
  assign bus.out_trans_valid_o         = r_out_valid;
  assign bus.out_trans_address_o       = r_cur_addr;
  assign bus.out_trans_cs_o            = r_cs;
  assign bus.out_trans_write_o         = r_write;
  assign bus.out_trans_burst_type_o    = r_burst_type;
  assign bus.out_trans_address_space_o = r_address_space;
  assign bus.out_trans_burst_o         = w_out_burst;
  assign bus.b_valid_o                 = r_b_valid;
  assign bus.b_error_o                 = r_b_error;

  // Only the final chunk's last beat closes the upstream read burst
  assign bus.rx_valid_o     = bus.phy_rx_valid_i;
  assign bus.phy_rx_ready_o = bus.rx_ready_i;
  assign bus.rx_data_o      = bus.phy_rx_data_i;
  assign bus.rx_error_o     = bus.phy_rx_error_i;
  assign bus.rx_last_o      = bus.phy_rx_last_i && (r_state == ST_DRAIN) &&
                              (r_done == (r_issued - CNT_WIDTH'(1)));

  a_no_b_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ST_IDLE) |-> !bus.phy_b_valid_i);

  a_chunk_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_out_fire |-> (r_issued != '1));

endmodule

`default_nettype wire

// File: tb/tb_hyperbus_burst_splitter.sv
// ============================================================================
// Module   : tb_hyperbus_burst_splitter
// Purpose  : Directed self-checking bench for hyperbus_burst_splitter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hyperbus_burst_splitter;
  import hyperbus_pkg::*;

  logic clk;
  logic rst_n;

  hyperbus_burst_splitter_if #(.BURST_WIDTH(12), .NR_CS(2), .ADDR_WIDTH(32)) bus ();

  hyperbus_burst_splitter #(
    .BURST_WIDTH (12),
    .NR_CS       (2),
    .ADDR_WIDTH  (32),
    .PAGE_LOG2   (9),
    .CNT_WIDTH   (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int b_seen  = 0;

  logic [31:0] mon_addr[$];
  logic [11:0] mon_burst[$];
  logic [31:0] exp_addr[$];
  logic [11:0] exp_burst[$];

  always @(posedge clk) begin
    if (rst_n && bus.out_trans_valid_o && bus.out_trans_ready_i) begin
      mon_addr.push_back(bus.out_trans_address_o);
      mon_burst.push_back(bus.out_trans_burst_o);
    end
    if (bus.b_valid_o) b_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_trans(input trans_struct t);
    check("in_ready_idle", bus.in_trans_ready_o, 1);
    bus.in_trans_address_i       = t.address;
    bus.in_trans_cs_i            = t.cs;
    bus.in_trans_write_i         = t.write;
    bus.in_trans_burst_type_i    = t.burst_type;
    bus.in_trans_address_space_i = t.address_space;
    bus.in_trans_burst_i         = t.burst;
    bus.in_trans_valid_i         = 1'b1;
    tick();
    bus.in_trans_valid_i = 1'b0;
    check("out_valid_latency", bus.out_trans_valid_o, 1);
    check("out_cs", bus.out_trans_cs_o, t.cs);
    check("out_write", bus.out_trans_write_o, t.write);
    check("in_ready_busy", bus.in_trans_ready_o, 0);
  endtask

  task automatic wait_issue_done();
    int k = 0;
    while (bus.out_trans_valid_o && k < 100) begin
      tick();
      k++;
    end
    check("issue_timeout", bus.out_trans_valid_o, 0);
  endtask

  task automatic check_chunks(input string tag);
    check({tag, "_count"}, mon_addr.size(), exp_addr.size());
    foreach (exp_addr[i]) begin
      check($sformatf("%s_addr%0d", tag, i),
            (i < mon_addr.size()) ? mon_addr[i] : 32'hDEAD_BEEF, exp_addr[i]);
      check($sformatf("%s_burst%0d", tag, i),
            (i < mon_burst.size()) ? mon_burst[i] : 12'hFFF, exp_burst[i]);
    end
    mon_addr.delete();
    mon_burst.delete();
  endtask

  task automatic b_pulses(input int n, input logic [7:0] err_mask);
    for (int i = 0; i < n; i++) begin
      bus.phy_b_valid_i = 1'b1;
      bus.phy_b_error_i = err_mask[i];
      tick();
    end
    bus.phy_b_valid_i = 1'b0;
    bus.phy_b_error_i = 1'b0;
  endtask

  task automatic wait_b_valid();
    int k = 0;
    while (!bus.b_valid_o && k < 50) begin
      tick();
      k++;
    end
    check("b_valid_timeout", bus.b_valid_o, 1);
  endtask

  task automatic b_handshake();
    bus.b_ready_i = 1'b1;
    tick();
    bus.b_ready_i = 1'b0;
    check("b_valid_cleared", bus.b_valid_o, 0);
    check("in_ready_after_resp", bus.in_trans_ready_o, 1);
  endtask

  task automatic wait_in_ready();
    int k = 0;
    while (!bus.in_trans_ready_o && k < 50) begin
      tick();
      k++;
    end
    check("in_ready_timeout", bus.in_trans_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trans_struct t;
    int last_cnt;
    int last_idx;

    rst_n = 1'b0;
    bus.cfg_max_burst_i = '0;
    bus.in_trans_valid_i = 1'b0;
    bus.in_trans_address_i = '0;
    bus.in_trans_cs_i = '0;
    bus.in_trans_write_i = 1'b0;
    bus.in_trans_burst_type_i = 1'b1;
    bus.in_trans_address_space_i = 1'b0;
    bus.in_trans_burst_i = '0;
    bus.out_trans_ready_i = 1'b0;
    bus.phy_b_valid_i = 1'b0;
    bus.phy_b_error_i = 1'b0;
    bus.b_ready_i = 1'b0;
    bus.phy_rx_valid_i = 1'b0;
    bus.phy_rx_data_i = '0;
    bus.phy_rx_last_i = 1'b0;
    bus.phy_rx_error_i = 1'b0;
    bus.rx_ready_i = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", bus.in_trans_ready_o, 1);
    check("rst_out_valid", bus.out_trans_valid_o, 0);
    check("rst_b_valid", bus.b_valid_o, 0);
    check("rst_b_error", bus.b_error_o, 0);
    rst_n = 1'b1;
    tick();

    // Write 100 words @0, max 32 -> 32,32,32,4
    bus.cfg_max_burst_i = 12'd32;
    bus.out_trans_ready_i = 1'b1;
    t = '{cs: 2'b01, write: 1'b1, burst: 12'd100, burst_type: 1'b1, address_space: 1'b0, address: 32'h0};
    start_trans(t);
    wait_issue_done();
    exp_addr = '{32'h0, 32'h40, 32'h80, 32'hC0};
    exp_burst = '{12'd32, 12'd32, 12'd32, 12'd4};
    check_chunks("wr100");
    b_pulses(4, 8'h00);
    wait_b_valid();
    check("wr100_b_error", bus.b_error_o, 0);
    b_handshake();

    // Read 10 words @0x3F8, no limit -> 4 @0x3F8, 6 @0x400
    bus.cfg_max_burst_i = 12'd0;
    t = '{cs: 2'b10, write: 1'b0, burst: 12'd10, burst_type: 1'b1, address_space: 1'b0, address: 32'h3F8};
    start_trans(t);
    wait_issue_done();
    exp_addr = '{32'h3F8, 32'h400};
    exp_burst = '{12'd4, 12'd6};
    check_chunks("rd_page");
    bus.rx_ready_i = 1'b1;
    last_cnt = 0;
    last_idx = -1;
    for (int i = 0; i < 10; i++) begin
      bus.phy_rx_valid_i = 1'b1;
      bus.phy_rx_data_i = 16'hA500 + 16'(i);
      bus.phy_rx_last_i = (i == 3) || (i == 9);
      #1;
      if (bus.rx_last_o) begin
        last_cnt++;
        last_idx = i;
      end
      if (i == 5) begin
        check("rx_data_pass", bus.rx_data_o, 16'hA505);
        check("rx_valid_pass", bus.rx_valid_o, 1);
        check("phy_rx_ready_pass", bus.phy_rx_ready_o, 1);
      end
      tick();
    end
    bus.phy_rx_valid_i = 1'b0;
    bus.phy_rx_last_i = 1'b0;
    check("rx_last_count", last_cnt, 1);
    check("rx_last_beat", last_idx, 9);
    wait_in_ready();

    // Write 40 @0, max 16 -> 16,16,8; b pulses overlap issue, error on second
    bus.cfg_max_burst_i = 12'd16;
    t = '{cs: 2'b01, write: 1'b1, burst: 12'd40, burst_type: 1'b1, address_space: 1'b0, address: 32'h0};
    start_trans(t);
    b_pulses(3, 8'b010);
    wait_issue_done();
    exp_addr = '{32'h0, 32'h20, 32'h40};
    exp_burst = '{12'd16, 12'd16, 12'd8};
    check_chunks("wr_err");
    wait_b_valid();
    for (int i = 0; i < 5; i++) begin
      check("resp_hold_valid", bus.b_valid_o, 1);
      check("resp_hold_error", bus.b_error_o, 1);
      check("resp_hold_in_ready", bus.in_trans_ready_o, 0);
      tick();
    end
    b_handshake();

    // Wrapped read of 64 with max 16: single chunk, last passes through
    t = '{cs: 2'b01, write: 1'b0, burst: 12'd64, burst_type: 1'b0, address_space: 1'b0, address: 32'h100};
    start_trans(t);
    wait_issue_done();
    exp_addr = '{32'h100};
    exp_burst = '{12'd64};
    check_chunks("wrapped");
    bus.phy_rx_valid_i = 1'b1;
    bus.phy_rx_last_i = 1'b1;
    #1;
    check("wrapped_rx_last", bus.rx_last_o, 1);
    tick();
    bus.phy_rx_valid_i = 1'b0;
    bus.phy_rx_last_i = 1'b0;
    wait_in_ready();

    // Register-space write of 64 with max 16: single chunk
    t = '{cs: 2'b10, write: 1'b1, burst: 12'd64, burst_type: 1'b1, address_space: 1'b1, address: 32'h2000};
    start_trans(t);
    wait_issue_done();
    exp_addr = '{32'h2000};
    exp_burst = '{12'd64};
    check_chunks("regspace");
    b_pulses(1, 8'h00);
    wait_b_valid();
    check("regspace_b_error", bus.b_error_o, 0);
    b_handshake();

    // Zero-length linear write: one chunk of 0
    t = '{cs: 2'b01, write: 1'b1, burst: 12'd0, burst_type: 1'b1, address_space: 1'b0, address: 32'h10};
    start_trans(t);
    wait_issue_done();
    exp_addr = '{32'h10};
    exp_burst = '{12'd0};
    check_chunks("zero_len");
    b_pulses(1, 8'h01);
    wait_b_valid();
    check("zero_len_b_error", bus.b_error_o, 1);
    b_handshake();

    // Stalled chunk keeps its length; then reset after 2 of 4 chunks
    bus.cfg_max_burst_i = 12'd32;
    bus.out_trans_ready_i = 1'b0;
    t = '{cs: 2'b01, write: 1'b1, burst: 12'd100, burst_type: 1'b1, address_space: 1'b0, address: 32'h0};
    start_trans(t);
    check("stall_burst_first", bus.out_trans_burst_o, 12'd32);
    tick();
    bus.cfg_max_burst_i = 12'd8;
    #1;
    check("stall_burst_held", bus.out_trans_burst_o, 12'd32);
    check("stall_addr_held", bus.out_trans_address_o, 32'h0);
    bus.cfg_max_burst_i = 12'd32;
    bus.out_trans_ready_i = 1'b1;
    tick();
    tick();
    bus.out_trans_ready_i = 1'b0;
    b_seen = 0;
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", bus.out_trans_valid_o, 0);
    check("midrst_in_ready", bus.in_trans_ready_o, 1);
    rst_n = 1'b1;
    exp_addr = '{32'h0, 32'h40};
    exp_burst = '{12'd32, 12'd32};
    check_chunks("midrst");
    for (int i = 0; i < 10; i++) tick();
    check("midrst_no_b_valid", b_seen, 0);
    check("midrst_idle_ready", bus.in_trans_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hyperbus_burst_splitter.md
Name: hyperbus_burst_splitter

Overview:
- Sits between the AXI-side transaction generator and the PHY, in the PHY clock domain after the transaction CDC.
- Splits one linear memory burst into chunks that respect a runtime maximum length and a fixed page boundary, then issues them back to back.
- Merges the per-chunk write responses into one response and masks the read-data last flag on every chunk except the final one.
- Enables NR_CS-generic, long-burst operation while keeping each chip-select low time within device limits.

Parameters:
- BURST_WIDTH, 12: width of burst length fields, in 16-bit words.
- NR_CS, 2: number of chip selects; width of the one-hot cs field.
- ADDR_WIDTH, 32: byte address width.
- PAGE_LOG2, 9: log2 of the page size in words; chunks never cross a 2^PAGE_LOG2-word boundary.
- CNT_WIDTH, 8: width of the chunk counters; bounds the number of chunks per transaction.

Ports:
- clk_i  in  1  PHY-domain clock.
- rst_ni  in  1  synchronous active-low reset.
- cfg_max_burst_i  in  BURST_WIDTH  maximum chunk length in words; 0 disables the length limit.
- in_trans_valid_i / in_trans_ready_o  in/out  1  upstream transaction handshake.
- in_trans_address_i  in  ADDR_WIDTH  byte address; bit 0 ignored.
- in_trans_cs_i  in  NR_CS  one-hot chip select.
- in_trans_write_i, in_trans_burst_type_i, in_trans_address_space_i  in  1 each  burst_type 1=linear, 0=wrapped; address_space 1=register.
- in_trans_burst_i  in  BURST_WIDTH  word count.
- out_trans_valid_o / out_trans_ready_i  out/in  1  chunk handshake toward the PHY.
- out_trans_address_o, out_trans_cs_o, out_trans_write_o, out_trans_burst_type_o, out_trans_address_space_o, out_trans_burst_o  out  same widths as the inputs.
- phy_b_valid_i, phy_b_error_i  in  1  per-chunk write response pulse; there is no ready.
- b_valid_o / b_ready_i  out/in  1  merged write response handshake.
- b_error_o  out  1  OR of all chunk errors.
- phy_rx_valid_i / phy_rx_ready_o  in/out  1  read data from the PHY.
- phy_rx_data_i  in  16  read data word.
- phy_rx_last_i, phy_rx_error_i  in  1  per-chunk last flag and error.
- rx_valid_o / rx_ready_i  out/in  1  read data toward the AXI side.
- rx_data_o  out  16  read data word.
- rx_last_o, rx_error_o  out  1  last is asserted only on the final chunk's last beat.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - State returns to IDLE; all counters and registers clear.
  - in_trans_ready_o=1; out_trans_valid_o=0; b_valid_o=0; b_error_o=0.
  - A reset mid-transaction abandons it; no response is produced.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - in_trans_ready_o=1, asserted only in IDLE.
  - On handshake, register all fields: cur_addr, remaining=burst, issued=0, done=0, err=0. Next state is ISSUE.
- Pass-through (exactly one chunk, no splitting): address_space=1, or burst_type=0, or burst=0.
- Chunk length (combinational from registers):
  - chunk = min(remaining, cfg_max_burst_i if nonzero, 2^PAGE_LOG2 - word_addr[PAGE_LOG2-1:0]).
  - word_addr = cur_addr>>1.
  - cfg_max_burst_i is sampled each chunk; changing it mid-transaction affects only later chunks.
- ISSUE:
  - out_trans_valid_o=1; out_trans fields are stable while valid and not ready.
  - On handshake: cur_addr += chunk*2, remaining -= chunk, issued++.
  - When remaining reaches 0, go to DRAIN.
- Issue latency: first out_trans_valid_o one cycle after the input handshake; back-to-back chunks at one per cycle if ready stays high.
- Completion counting (every state except IDLE):
  - done increments on phy_b_valid_i for writes, or on an accepted phy_rx beat with phy_rx_last_i for reads.
  - err |= phy_b_error_i on each b pulse.
  - Completions arriving in the same cycle as a chunk issue are counted; no event is lost.
- DRAIN:
  - Writes: when done==issued, go to RESP.
  - Reads: when done==issued, go to IDLE.
- RESP:
  - b_valid_o=1 and b_error_o=err, held until b_ready_i; then go to IDLE.
  - Reads never enter RESP.
- Read path:
  - Combinational pass-through: rx_valid_o=phy_rx_valid_i, phy_rx_ready_o=rx_ready_i, data and error unchanged.
  - rx_last_o = phy_rx_last_i AND (state==DRAIN) AND (done==issued-1).
- Spurious events: phy_b_valid_i in IDLE is ignored and must be flagged by an assertion.
- Counters: done and issued are CNT_WIDTH bits wide. A transaction that needs more than 2^CNT_WIDTH-1 chunks is illegal and must be flagged by an assertion.

Decomposition:
- hyperbus_pkg: trans_struct typedef (cs, write, burst, burst_type, address_space, address) parametrised via localparams, plus the burst_type and address_space encodings.
- Chunk-length computation is a natural sub-module: hyperbus_chunk_calc (purely combinational min of three terms).

Test Plan:
- Write, addr 0x0, burst 100, cfg_max 32, PAGE_LOG2 9 -> chunks 32,32,32,4 at byte addrs 0x0,0x40,0x80,0xC0; four b pulses produce one b_valid_o with error 0.
- Read, addr 0x3F8 (word 0x1FC), burst 10, cfg_max 0 -> chunks of 4 words @0x3F8 and 6 words @0x400; rx_last_o asserted once, on beat 10.
- Write split into 3 chunks, phy_b_error_i=1 on the second pulse only -> single response with b_error_o=1.
- Wrapped burst (burst_type 0) of 64, cfg_max 16 -> one chunk of 64, no split; same for address_space=1.
- Reset asserted during ISSUE after 2 of 4 chunks -> next cycle out_trans_valid_o=0 and in_trans_ready_o=1; no b_valid_o is ever produced.
- b_ready_i held low 5 cycles in RESP -> b_valid_o held with stable error; in_trans_ready_o stays 0 until the response handshake.
